atm_ledger_arbiter: RTL

- Shares one account ledger (balance register plus add/subtract datapath) between NUM_REQ ATM terminal controllers.
- Grants one pending transaction at a time using round-robin arbitration.
- Performs the read-modify-write on the balance and returns a per-terminal completion pulse with a status code.
- Sits between the terminal controllers (requesters) and the single account balance. The block owns the balance register.

---
 rtl/atm_ledger_defs.sv | 26 ++
 rtl/rr_arbiter.sv | 35 +++
 rtl/atm_ledger_arbiter.sv | 152 +++++++++++++++
 3 files changed

// File: rtl/atm_ledger_defs.sv
// Shared encodings for the ATM ledger arbiter: request types, completion
// status codes and FSM states.
package atm_ledger_defs;

   typedef enum logic [1:0] {
      TYPE_DEPOSIT  = 2'd0,
      TYPE_WITHDRAW = 2'd1,
      TYPE_INQUIRY  = 2'd2,
      TYPE_RSVD     = 2'd3
   } req_type_e;

   typedef enum logic [2:0] {
      ST_OK       = 3'd0,
      ST_INSUF    = 3'd1,
      ST_OVF      = 3'd2,
      ST_BAD_TYPE = 3'd3,
      ST_LOCKED   = 3'd4
   } status_e;

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_EXEC = 2'd1,
      S_RESP = 2'd2
   } state_e;

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin pick: first pending request after last_grant,
// wrapping modulo NUM_REQ. The parent registers the result.
module rr_arbiter #(
   parameter int NUM_REQ = 4
) (
   input  logic [NUM_REQ-1:0] req,
   input  logic [2:0]         last_grant,
   output logic [NUM_REQ-1:0] gnt,
   output logic [2:0]         gnt_idx,
   output logic               gnt_any
);

   localparam int IDX_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

   int               pos;
   logic [IDX_W-1:0] sel;

   always_comb begin
      gnt     = '0;
      gnt_idx = '0;
      gnt_any = 1'b0;
      pos     = 0;
      sel     = '0;
      for (int k = 1; k <= NUM_REQ; k++) begin
         pos = (int'(last_grant) + k) % NUM_REQ;
         sel = IDX_W'(pos);
         if (!gnt_any && req[sel]) begin
            gnt_any  = 1'b1;
            gnt[sel] = 1'b1;
            gnt_idx  = 3'(pos);
         end
      end
   end

endmodule

// File: rtl/atm_ledger_arbiter.sv
// Shared account ledger: round-robin grants one terminal at a time and runs
// an IDLE -> EXEC -> RESP read-modify-write on the owned balance register.
module atm_ledger_arbiter
   import atm_ledger_defs::*;
#(
   parameter int               NUM_REQ      = 4,
   parameter int               AMT_W        = 32,
   parameter int               BAL_W        = 64,
   parameter logic [BAL_W-1:0] INIT_BALANCE = BAL_W'(4500)
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic [NUM_REQ-1:0]       req_valid,
   input  logic [2*NUM_REQ-1:0]     req_type,
   input  logic [AMT_W*NUM_REQ-1:0] req_amount,
   input  logic                     acct_lock,
   output logic [NUM_REQ-1:0]       req_ready,
   output logic [NUM_REQ-1:0]       resp_valid,
   output logic [2:0]               resp_status,
   output logic [2:0]               grant_id,
   output logic                     busy,
   output logic [BAL_W-1:0]         balance
);

   state_e             state_q, state_d;
   logic [2:0]         last_grant_q, last_grant_d;
   logic [2:0]         grant_id_q, grant_id_d;
   logic [1:0]         op_type_q, op_type_d;
   logic [AMT_W-1:0]   op_amt_q, op_amt_d;
   logic [BAL_W-1:0]   balance_q, balance_d;
   logic [2:0]         resp_status_q, resp_status_d;
   logic [NUM_REQ-1:0] req_ready_q, req_ready_d;
   logic [NUM_REQ-1:0] resp_valid_q, resp_valid_d;
   logic               busy_q, busy_d;

   logic [NUM_REQ-1:0] arb_gnt;
   logic [2:0]         arb_idx;
   logic               arb_any;

   rr_arbiter #(.NUM_REQ(NUM_REQ)) u_rr (
      .req        (req_valid),
      .last_grant (last_grant_q),
      .gnt        (arb_gnt),
      .gnt_idx    (arb_idx),
      .gnt_any    (arb_any)
   );

   // One-hot grant drives an AND-OR slice mux, so no variable-index selects.
   logic [1:0]       win_type;
   logic [AMT_W-1:0] win_amt;

   always_comb begin
      win_type = '0;
      win_amt  = '0;
      for (int i = 0; i < NUM_REQ; i++) begin
         if (arb_gnt[i]) begin
            win_type = req_type[2*i +: 2];
            win_amt  = req_amount[AMT_W*i +: AMT_W];
         end
      end
   end

   logic [BAL_W:0]   amt_ext;
   logic [BAL_W:0]   sum;
   logic [BAL_W-1:0] exec_bal;
   logic [2:0]       exec_status;

   always_comb begin
      amt_ext     = (BAL_W+1)'(op_amt_q);
      sum         = {1'b0, balance_q} + amt_ext;
      exec_bal    = balance_q;
      exec_status = ST_OK;
      if (op_type_q == TYPE_RSVD) begin
         exec_status = ST_BAD_TYPE;
      end else if (acct_lock && op_type_q != TYPE_INQUIRY) begin
         exec_status = ST_LOCKED;
      end else if (op_type_q == TYPE_DEPOSIT) begin
         if (sum[BAL_W]) exec_status = ST_OVF;
         else            exec_bal    = sum[BAL_W-1:0];
      end else if (op_type_q == TYPE_WITHDRAW) begin
         if (amt_ext > {1'b0, balance_q}) exec_status = ST_INSUF;
         else                             exec_bal    = balance_q - amt_ext[BAL_W-1:0];
      end
   end

   always_comb begin
      state_d       = state_q;
      last_grant_d  = last_grant_q;
      grant_id_d    = grant_id_q;
      op_type_d     = op_type_q;
      op_amt_d      = op_amt_q;
      balance_d     = balance_q;
      resp_status_d = resp_status_q;
      req_ready_d   = '0;
      resp_valid_d  = '0;
      case (state_q)
         S_IDLE: begin
            if (arb_any) begin
               grant_id_d  = arb_idx;
               op_type_d   = win_type;
               op_amt_d    = win_amt;
               req_ready_d = arb_gnt;
               state_d     = S_EXEC;
            end
         end
         S_EXEC: begin
            balance_d     = exec_bal;
            resp_status_d = exec_status;
            resp_valid_d  = NUM_REQ'(1) << grant_id_q;
            last_grant_d  = grant_id_q;
            state_d       = S_RESP;
         end
         S_RESP:  state_d = S_IDLE;
         default: state_d = S_IDLE;
      endcase
      busy_d = (state_d != S_IDLE);
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q       <= S_IDLE;
         last_grant_q  <= 3'(NUM_REQ-1);
         grant_id_q    <= '0;
         op_type_q     <= '0;
         op_amt_q      <= '0;
         balance_q     <= INIT_BALANCE;
         resp_status_q <= '0;
         req_ready_q   <= '0;
         resp_valid_q  <= '0;
         busy_q        <= 1'b0;
      end else begin
         state_q       <= state_d;
         last_grant_q  <= last_grant_d;
         grant_id_q    <= grant_id_d;
         op_type_q     <= op_type_d;
         op_amt_q      <= op_amt_d;
         balance_q     <= balance_d;
         resp_status_q <= resp_status_d;
         req_ready_q   <= req_ready_d;
         resp_valid_q  <= resp_valid_d;
         busy_q        <= busy_d;
      end
   end

   assign req_ready   = req_ready_q;
   assign resp_valid  = resp_valid_q;
   assign resp_status = resp_status_q;
   assign grant_id    = grant_id_q;
   assign busy        = busy_q;
   assign balance     = balance_q;

endmodule
